// File: rtl/fir_stream_driver_pkg.sv
// Shared definitions for the FIR stream driver: defaults, FSM encoding and
// the index-width helper used by the driver, its interface and the FIFO.
package fir_stream_driver_pkg;

  localparam int unsigned DEF_LENGTH     = 20;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_SEND_COEFF = 3'd2,
    S_STREAM     = 3'd3,
    S_DRAIN      = 3'd4,
    S_STOP       = 3'd5
  } state_e;

  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_stream_driver_if.sv
// Control, coefficient and sample bus between an upstream controller and the
// FIR stream driver; master is the controller side, slave the driver side.
interface fir_stream_driver_if
  import fir_stream_driver_pkg::*;
#(
  parameter int unsigned LENGTH     = DEF_LENGTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int unsigned AW = addr_width(LENGTH);

  logic                         coeffWrEn;
  logic [AW-1:0]                coeffWrAddr;
  logic signed [DATA_WIDTH-1:0] coeffWrData;
  logic                         startFlag;
  logic                         stopFlag;
  logic                         sampleValid;
  logic signed [DATA_WIDTH-1:0] sampleIn;
  logic                         sampleReady;
  logic                         loadCoeff;
  logic signed [DATA_WIDTH-1:0] coeffOut;
  logic                         loadDataFlag;
  logic signed [DATA_WIDTH-1:0] dataOut;
  logic                         stopDataLoadFlag;
  logic                         busy;

  modport master (
    output coeffWrEn, coeffWrAddr, coeffWrData, startFlag, stopFlag,
           sampleValid, sampleIn,
    input  sampleReady, loadCoeff, coeffOut, loadDataFlag, dataOut,
           stopDataLoadFlag, busy
  );

  modport slave (
    input  coeffWrEn, coeffWrAddr, coeffWrData, startFlag, stopFlag,
           sampleValid, sampleIn,
    output sampleReady, loadCoeff, coeffOut, loadDataFlag, dataOut,
           stopDataLoadFlag, busy
  );

endinterface

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers and a synchronous flush.
// No write-to-read bypass: a pushed entry is visible from the next cycle.
module fir_sample_fifo
  import fir_stream_driver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_wr, do_rd;

  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fir_stream_driver.sv
// Session controller feeding an FIR: streams the stored coefficients once per
// session, then forwards buffered samples until a requested stop drains them.
module fir_stream_driver
  import fir_stream_driver_pkg::*;
#(
  parameter int unsigned LENGTH     = DEF_LENGTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clock,
  input  logic                resetN,
  fir_stream_driver_if.slave  bus
);
  localparam int unsigned   AW       = addr_width(LENGTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(LENGTH - 1);

  state_e                       state_q, state_d;
  logic [AW-1:0]                cnt_q, cnt_d;
  logic                         stop_pend_q, stop_pend_d;
  logic                         ready_en_q, ready_en_d;
  logic signed [DATA_WIDTH-1:0] store_q [LENGTH];
  logic signed [DATA_WIDTH-1:0] store_d [LENGTH];
  logic signed [DATA_WIDTH-1:0] data_q, data_d;

  logic                         fifo_full, fifo_empty, fifo_flush;
  logic                         fifo_push, fifo_pop, sample_ready;
  logic [DATA_WIDTH-1:0]        fifo_rd_data;

  // Holds sampleReady low through reset and for the first edge after release.
  assign ready_en_d   = 1'b1;
  assign sample_ready = ready_en_q && !fifo_full && (state_q != S_STOP);
  assign fifo_push    = bus.sampleValid && sample_ready;

  assign bus.sampleReady  = sample_ready;
  assign bus.loadDataFlag = fifo_pop;
  assign bus.dataOut      = data_d;

  always_comb begin
    data_d = data_q;
    if (fifo_pop) data_d = $signed(fifo_rd_data);
  end

  always_comb begin
    store_d = store_q;
    if (state_q == S_IDLE && bus.coeffWrEn && bus.coeffWrAddr <= LAST_IDX)
      store_d[bus.coeffWrAddr] = bus.coeffWrData;
  end

  always_comb begin
    state_d              = state_q;
    cnt_d                = '0;
    stop_pend_d          = stop_pend_q;
    fifo_pop             = 1'b0;
    fifo_flush           = 1'b0;
    bus.loadCoeff        = 1'b0;
    bus.coeffOut         = '0;
    bus.stopDataLoadFlag = 1'b0;
    bus.busy             = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.startFlag) state_d = S_ARM;
      end
      S_ARM: begin
        bus.loadCoeff = 1'b1;
        if (bus.stopFlag) stop_pend_d = 1'b1;
        state_d = S_SEND_COEFF;
      end
      S_SEND_COEFF: begin
        bus.coeffOut = store_q[cnt_q];
        if (bus.stopFlag) stop_pend_d = 1'b1;
        if (cnt_q == LAST_IDX) state_d = S_STREAM;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_STREAM: begin
        fifo_pop = !fifo_empty;
        if (bus.stopFlag) stop_pend_d = 1'b1;
        if (stop_pend_q || bus.stopFlag) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        fifo_pop = !fifo_empty;
        if (fifo_empty) state_d = S_STOP;
      end
      S_STOP: begin
        bus.stopDataLoadFlag = 1'b1;
        fifo_flush           = 1'b1;
        stop_pend_d          = 1'b0;
        state_d              = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      ready_en_q  <= 1'b0;
      store_q     <= '{default: '0};
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      ready_en_q  <= ready_en_d;
      store_q     <= store_d;
      data_q      <= data_d;
    end
  end

  fir_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (resetN),
    .flush   (fifo_flush),
    .wr_en   (fifo_push),
    .wr_data (bus.sampleIn),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver: coefficient sessions, sample ordering,
// FIFO full back-pressure, stop/drain, ignored writes and mid-session reset.
module tb_fir_stream_driver;
  import fir_stream_driver_pkg::*;

  localparam int unsigned LENGTH = 20;
  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 16;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  fir_stream_driver_if #(.LENGTH(LENGTH), .DATA_WIDTH(DW)) bus ();

  fir_stream_driver #(
    .LENGTH     (LENGTH),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_coef [LENGTH];
  int exp_q  [$];
  int pend_q [$];
  int sched_c [$];
  int sched_v [$];
  int last_pop = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_inputs();
    bus.coeffWrEn   = 1'b0;
    bus.coeffWrAddr = '0;
    bus.coeffWrData = '0;
    bus.startFlag   = 1'b0;
    bus.stopFlag    = 1'b0;
    bus.sampleValid = 1'b0;
    bus.sampleIn    = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_lcoef"}, int'(bus.loadCoeff), 0);
    chk({tag, "_coef"},  int'(bus.coeffOut), 0);
    chk({tag, "_ldata"}, int'(bus.loadDataFlag), 0);
    chk({tag, "_data"},  int'(bus.dataOut), 0);
    chk({tag, "_stop"},  int'(bus.stopDataLoadFlag), 0);
    chk({tag, "_ready"}, int'(bus.sampleReady), 0);
  endtask

  // Session starts with startFlag at cycle 0; ARM is cycle 1, coefficients
  // occupy cycles 2..LENGTH+1 and streaming begins at cycle LENGTH+2.
  task automatic run_session(input int stop_at, input int wr_at, input int restart_at,
                             input int full_at, input int exp_pops);
    int  pops     = 0;
    int  accepted = 0;
    bit  acc      = 1'b0;
    int  acc_val  = 0;
    bit  done     = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (acc) begin
        exp_q.push_back(acc_val);
        accepted++;
      end
      foreach (sched_c[i]) if (sched_c[i] == c) pend_q.push_back(sched_v[i]);
      bus.startFlag   = (c == 0) || (c == restart_at);
      bus.stopFlag    = (c == stop_at);
      bus.coeffWrEn   = (c == wr_at);
      bus.coeffWrAddr = 5'd3;
      bus.coeffWrData = 8'sd77;
      bus.sampleValid = (pend_q.size() != 0);
      bus.sampleIn    = (pend_q.size() != 0) ? DW'(pend_q[0]) : '0;
      #1;
      acc = bus.sampleValid && bus.sampleReady;
      if (acc) acc_val = pend_q.pop_front();
      if (bus.stopDataLoadFlag) begin
        chk("stop_pops",      pops, exp_pops);
        chk("stop_fifo_left", exp_q.size(), 0);
        chk("stop_ready",     int'(bus.sampleReady), 0);
        chk("stop_coeff",     int'(bus.coeffOut), 0);
        done = 1'b1;
      end else begin
        chk("busy",       int'(bus.busy), int'(c != 0));
        chk("load_coeff", int'(bus.loadCoeff), int'(c == 1));
        chk("coeff_out",  int'(bus.coeffOut),
            (c >= 2 && c < 2 + int'(LENGTH)) ? exp_coef[c-2] : 0);
        if (c >= 2 + int'(LENGTH)) begin
          chk("load_data", int'(bus.loadDataFlag), int'(exp_q.size() != 0));
          if (bus.loadDataFlag && exp_q.size() != 0) begin
            chk("data_out", int'(bus.dataOut), exp_q[0]);
            last_pop = exp_q.pop_front();
            pops++;
          end else begin
            chk("data_hold", int'(bus.dataOut), last_pop);
          end
        end else begin
          chk("load_data_early", int'(bus.loadDataFlag), 0);
          chk("data_hold_early", int'(bus.dataOut), last_pop);
        end
        if (c == full_at) begin
          chk("full_ready", int'(bus.sampleReady), 0);
          chk("full_count", accepted, 16);
        end
      end
    end
    if (!done) chk("session_timeout", 0, 1);
    clear_inputs();
    @(negedge clock);
    #1;
    chk("after_busy",  int'(bus.busy), 0);
    chk("after_stop",  int'(bus.stopDataLoadFlag), 0);
    chk("after_ready", int'(bus.sampleReady), 1);
    sched_c.delete();
    sched_v.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    @(negedge clock);
    #1;
    chk_all_zero("reset");
    resetN = 1'b1;
    #1;
    chk("ready_at_release", int'(bus.sampleReady), 0);
    @(negedge clock);
    #1;
    chk("ready_after_release", int'(bus.sampleReady), 1);

    // stopFlag in IDLE must not start anything
    bus.stopFlag = 1'b1;
    @(negedge clock);
    bus.stopFlag = 1'b0;
    #1;
    chk("idle_stop_busy", int'(bus.busy), 0);

    for (int k = 0; k < int'(LENGTH); k++) begin
      bus.coeffWrEn   = 1'b1;
      bus.coeffWrAddr = 5'(k);
      bus.coeffWrData = 8'(k + 1);
      exp_coef[k]     = k + 1;
      @(negedge clock);
    end
    bus.coeffWrAddr = 5'd20;
    bus.coeffWrData = 8'sd99;
    @(negedge clock);
    clear_inputs();

    // Session 1: 5,-3,7 during SEND_COEFF, 9 into an empty FIFO in STREAM,
    // write and restart attempts in STREAM, stop in STREAM.
    sched_c = '{2, 2, 2, 25};
    sched_v = '{5, -3, 7, 9};
    run_session(27, 23, 24, -1, 4);

    // Session 2: 17 samples offered from ARM onwards; 16 fit, 17th held.
    for (int i = 1; i <= 17; i++) begin
      sched_c.push_back(1);
      sched_v.push_back(i);
    end
    run_session(45, -1, -1, 20, 17);

    // Session 3: stop latched during SEND_COEFF with 4 samples queued.
    sched_c = '{3, 3, 3, 3};
    sched_v = '{11, 12, 13, 14};
    run_session(10, -1, -1, -1, 4);

    // Session 4: reset at coefficient index 7.
    for (int c = 0; c <= 9; c++) begin
      @(negedge clock);
      bus.startFlag = (c == 0);
    end
    #1;
    chk("abort_k7_coeff", int'(bus.coeffOut), 8);
    resetN = 1'b0;
    #1;
    chk_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("abort_no_stop", int'(bus.stopDataLoadFlag), 0);
    end
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    #1;
    chk("abort_ready", int'(bus.sampleReady), 1);
    last_pop = 0;
    foreach (exp_coef[k]) exp_coef[k] = 0;

    // Session 5: store was zeroed by reset.
    run_session(22, -1, -1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_stream_driver.md
FIR_STREAM_DRIVER -- requirements
Module: fir_stream_driver

Interface
REQ-001 Parameter LENGTH, default 20: number of FIR taps (coefficients) sent per session.
REQ-002 Parameter DATA_WIDTH, default 8: width of coefficients and samples (signed).
REQ-003 Parameter FIFO_DEPTH, default 16, power of two: sample buffer depth.
REQ-004 clock  in  1  single system clock; all logic on rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 coeffWrEn  in  1  coefficient store write strobe.
REQ-007 coeffWrAddr  in  clog2(LENGTH)  coefficient store write index.
REQ-008 coeffWrData  in  DATA_WIDTH  signed coefficient write value.
REQ-009 startFlag  in  1  one-cycle request to begin a session.
REQ-010 stopFlag  in  1  one-cycle request to end the session after the FIFO drains.
REQ-011 sampleValid  in  1  upstream sample present.
REQ-012 sampleIn  in  DATA_WIDTH  signed upstream sample.
REQ-013 sampleReady  out  1  FIFO can accept; transfer when sampleValid & sampleReady.
REQ-014 loadCoeff  out  1  FIR session start pulse.
REQ-015 coeffOut  out  DATA_WIDTH  serial coefficient stream to the FIR.
REQ-016 loadDataFlag  out  1  dataOut valid this cycle.
REQ-017 dataOut  out  DATA_WIDTH  sample stream to the FIR.
REQ-018 stopDataLoadFlag  out  1  one-cycle FIR session end pulse.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ARM, SEND_COEFF, STREAM, DRAIN, STOP; unused encodings SHALL go to IDLE.
REQ-021 Coefficient store writes SHALL occur only in IDLE; writes in other states, and addresses >= LENGTH, SHALL be ignored.
REQ-022 IDLE -> ARM on startFlag; stopFlag in IDLE SHALL be ignored.
REQ-023 ARM lasts one cycle, SHALL drive loadCoeff=1, then go to SEND_COEFF.
REQ-024 SEND_COEFF lasts exactly LENGTH cycles; in its k-th cycle (k=0..LENGTH-1) coeffOut SHALL equal store[k].
REQ-025 coeffOut SHALL be 0 in every cycle outside SEND_COEFF.
REQ-026 After SEND_COEFF the FSM SHALL enter STREAM.
REQ-027 In STREAM and DRAIN, loadDataFlag SHALL be 1 exactly when the FIFO is non-empty; that cycle pops one entry and drives it on dataOut.
REQ-028 dataOut SHALL hold its last value when loadDataFlag=0.
REQ-029 The FIFO SHALL accept samples in every state except STOP; sampleReady = not full and state != STOP.
REQ-030 A simultaneous push and pop on a full FIFO SHALL NOT be allowed; sampleReady stays 0 while full.
REQ-031 A simultaneous push and pop on an empty FIFO SHALL NOT bypass; the pushed sample is popped no earlier than the next cycle.
REQ-032 stopFlag received in ARM, SEND_COEFF or STREAM SHALL be latched; on entering or already being in STREAM with the flag latched, the FSM SHALL go to DRAIN.
REQ-033 DRAIN -> STOP in the cycle after the FIFO becomes empty.
REQ-034 STOP lasts one cycle, SHALL drive stopDataLoadFlag=1, clear the FIFO and the latched stop, then go to IDLE.
REQ-035 startFlag outside IDLE SHALL be ignored.
REQ-036 The coefficient store SHALL retain its contents across sessions; it is cleared only by reset.
REQ-037 FIFO pointers SHALL use clog2(FIFO_DEPTH)+1 bits with wrap-around; full/empty SHALL be derived from the MSB comparison.

Reset
REQ-038 On resetN=0: state IDLE; all outputs 0 except sampleReady=0; FIFO empty; store all zeros; stop latch cleared.
REQ-039 Reset mid-session SHALL abort immediately without a stopDataLoadFlag pulse.
REQ-040 sampleReady SHALL rise the first cycle after resetN deasserts.

Structure
REQ-041 A shared package SHALL hold the state encoding, default LENGTH/DATA_WIDTH/FIFO_DEPTH and the address-width function.
REQ-042 The FIFO SHALL be a sub-module, fir_sample_fifo (synchronous, same clock/reset, flush input).

Verification
REQ-043 Write store[k]=k+1 (k=0..19), pulse startFlag -> loadCoeff=1 for 1 cycle, then coeffOut = 1,2,...,20 on 20 consecutive cycles, then 0.
REQ-044 Push samples 5,-3,7 during SEND_COEFF -> after SEND_COEFF, loadDataFlag=1 for 3 cycles with dataOut = 5,-3,7.
REQ-045 Push 17 samples with no pop (in ARM/SEND_COEFF, LENGTH=20) -> sampleReady=0 after the 16th; the 17th is held upstream and not lost.
REQ-046 Pulse stopFlag in STREAM with 4 samples queued -> 4 pops, then stopDataLoadFlag=1 for 1 cycle, then IDLE with busy=0.
REQ-047 Assert resetN=0 during SEND_COEFF at k=7 -> all outputs 0 immediately, no stopDataLoadFlag, store zeroed, next start sends 20 zeros.
REQ-048 coeffWrEn with addr 3 during STREAM -> ignored; the next session sends the previous store[3].
